// File: rtl/e203_wbck_pkg.sv
// Shared definitions for the long-pipe write-back scheduler: unit
// encodings, the tag recorded per dispatched instruction, and defaults.
package e203_wbck_pkg;

    localparam logic UNIT_LSU = 1'b0;
    localparam logic UNIT_MDV = 1'b1;

    localparam int WBCK_DEPTH   = 2;
    localparam int WBCK_RFIDX_W = 5;

    // One outstanding long-pipe instruction: who completes it and where it writes
    typedef struct packed {
        logic                    unit;
        logic                    rdwen;
        logic [WBCK_RFIDX_W-1:0] rdidx;
        logic                    rdfpu;
    } wbck_tag_t;

endpackage

// File: rtl/e203_exu_wbck_tagfifo.sv
// Small synchronous tag FIFO with flush. Pointers carry an extra wrap bit
// so full and empty can be told apart without a separate counter.
module e203_exu_wbck_tagfifo
    import e203_wbck_pkg::*;
#(
    parameter int DEPTH = WBCK_DEPTH,
    parameter int PTR_W = 1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wbck_tag_t       push_tag,
    input  logic            pop,
    input  logic            flush,
    output wbck_tag_t       head_tag,
    output logic            full,
    output logic            empty,
    output logic [PTR_W:0]  cnt
);

    wbck_tag_t       entries [DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cnt      = wr_ptr - rd_ptr;
    assign head_tag = entries[rd_ptr[PTR_W-1:0]];

    // Flush wins over both push and pop, so neither pointer moves on its own that cycle
    assign do_push  = push & ~full  & ~flush;
    assign do_pop   = pop  & ~empty & ~flush;

    // Pointer update: flush drops every outstanding entry by catching rd up to wr
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage: written at the write pointer slot, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (do_push) begin
            entries[wr_ptr[PTR_W-1:0]] <= push_tag;
        end
    end

endmodule

// File: rtl/e203_exu_longp_wbck_sched.sv
// In-order scheduler for long-pipe write-back. Only the unit owning the
// FIFO head may complete; its response goes to the regfile arbiter, is
// swallowed (no rd), or is diverted to the exception port on LSU error.
module e203_exu_longp_wbck_sched
    import e203_wbck_pkg::*;
#(
    parameter int DEPTH   = WBCK_DEPTH,
    parameter int PTR_W   = 1,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = WBCK_RFIDX_W
)
(
    input  logic               clk,
    input  logic               rst,

    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic               disp_unit,
    input  logic               disp_rdwen,
    input  logic [RFIDX_W-1:0] disp_rdidx,
    input  logic               disp_rdfpu,

    input  logic               flush,

    input  logic               lsu_wbck_valid,
    output logic               lsu_wbck_ready,
    input  logic [XLEN-1:0]    lsu_wbck_wdat,
    input  logic               lsu_wbck_err,

    input  logic               mdv_wbck_valid,
    output logic               mdv_wbck_ready,
    input  logic [XLEN-1:0]    mdv_wbck_wdat,

    output logic               longp_wbck_o_valid,
    input  logic               longp_wbck_o_ready,
    output logic [XLEN-1:0]    longp_wbck_o_wdat,
    output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
    output logic               longp_wbck_o_rdfpu,

    output logic               excp_o_valid,
    input  logic               excp_o_ready,

    output logic               fifo_empty,
    output logic [PTR_W:0]     fifo_cnt
);

    wbck_tag_t disp_tag;
    wbck_tag_t head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      active;
    logic      hd_lsu;
    logic      hd_mdv;
    logic      hd_valid;
    logic      hd_err;
    logic      hd_accept;

    assign disp_tag = '{unit: disp_unit, rdwen: disp_rdwen, rdidx: disp_rdidx, rdfpu: disp_rdfpu};

    // Nothing is accepted or presented during reset or flush
    assign active     = ~rst & ~flush;
    assign disp_ready = ~full & active;
    assign push       = disp_valid & disp_ready;
    assign pop        = hd_valid & hd_accept & active;
    assign fifo_empty = empty;

    e203_exu_wbck_tagfifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tagfifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (disp_tag),
        .pop      (pop),
        .flush    (flush),
        .head_tag (head),
        .full     (full),
        .empty    (empty),
        .cnt      (fifo_cnt)
    );

    // Head decode: pick the owning unit, classify its response and route the handshake
    always_comb begin
        hd_lsu             = ~empty & (head.unit == UNIT_LSU);
        hd_mdv             = ~empty & (head.unit == UNIT_MDV);
        hd_valid           = (hd_lsu & lsu_wbck_valid) | (hd_mdv & mdv_wbck_valid);
        hd_err             = hd_lsu & lsu_wbck_err;
        hd_accept          = 1'b0;
        longp_wbck_o_valid = 1'b0;
        excp_o_valid       = 1'b0;
        lsu_wbck_ready     = 1'b0;
        mdv_wbck_ready     = 1'b0;
        if (active & ~empty) begin
            if (hd_err) begin
                excp_o_valid = hd_valid;
                hd_accept    = excp_o_ready;
            end else if (head.rdwen) begin
                longp_wbck_o_valid = hd_valid;
                hd_accept          = longp_wbck_o_ready;
            end else begin
                hd_accept = 1'b1;
            end
            lsu_wbck_ready = hd_lsu & hd_accept;
            mdv_wbck_ready = hd_mdv & hd_accept;
        end
    end

    // Write-back payload: only driven while a regfile write is being offered
    always_comb begin
        longp_wbck_o_wdat  = '0;
        longp_wbck_o_rdidx = '0;
        longp_wbck_o_rdfpu = 1'b0;
        if (longp_wbck_o_valid) begin
            longp_wbck_o_wdat  = hd_lsu ? lsu_wbck_wdat : mdv_wbck_wdat;
            longp_wbck_o_rdidx = head.rdidx;
            longp_wbck_o_rdfpu = head.rdfpu;
        end
    end

endmodule

// File: tb/tb_e203_exu_longp_wbck_sched.sv
// Self-checking bench for the long-pipe write-back scheduler: directed
// scenarios followed by random traffic, all checked against a queue model.
module tb_e203_exu_longp_wbck_sched;

    localparam int DEPTH   = 2;
    localparam int PTR_W   = 1;
    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;

    typedef struct {
        bit             rst;
        bit             disp_valid;
        bit             disp_unit;
        bit             disp_rdwen;
        bit [4:0]       disp_rdidx;
        bit             disp_rdfpu;
        bit             flush;
        bit             lsu_valid;
        bit [31:0]      lsu_wdat;
        bit             lsu_err;
        bit             mdv_valid;
        bit [31:0]      mdv_wdat;
        bit             longp_ready;
        bit             excp_ready;
    } stim_t;

    typedef struct {
        bit       unit;
        bit       rdwen;
        bit [4:0] rdidx;
        bit       rdfpu;
    } ent_t;

    logic               clk;
    logic               rst;
    logic               disp_valid;
    logic               disp_ready;
    logic               disp_unit;
    logic               disp_rdwen;
    logic [RFIDX_W-1:0] disp_rdidx;
    logic               disp_rdfpu;
    logic               flush;
    logic               lsu_wbck_valid;
    logic               lsu_wbck_ready;
    logic [XLEN-1:0]    lsu_wbck_wdat;
    logic               lsu_wbck_err;
    logic               mdv_wbck_valid;
    logic               mdv_wbck_ready;
    logic [XLEN-1:0]    mdv_wbck_wdat;
    logic               longp_wbck_o_valid;
    logic               longp_wbck_o_ready;
    logic [XLEN-1:0]    longp_wbck_o_wdat;
    logic [RFIDX_W-1:0] longp_wbck_o_rdidx;
    logic               longp_wbck_o_rdfpu;
    logic               excp_o_valid;
    logic               excp_o_ready;
    logic               fifo_empty;
    logic [PTR_W:0]     fifo_cnt;

    int   num_checks;
    int   num_miscompares;
    ent_t model_q[$];

    e203_exu_longp_wbck_sched #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .disp_valid         (disp_valid),
        .disp_ready         (disp_ready),
        .disp_unit          (disp_unit),
        .disp_rdwen         (disp_rdwen),
        .disp_rdidx         (disp_rdidx),
        .disp_rdfpu         (disp_rdfpu),
        .flush              (flush),
        .lsu_wbck_valid     (lsu_wbck_valid),
        .lsu_wbck_ready     (lsu_wbck_ready),
        .lsu_wbck_wdat      (lsu_wbck_wdat),
        .lsu_wbck_err       (lsu_wbck_err),
        .mdv_wbck_valid     (mdv_wbck_valid),
        .mdv_wbck_ready     (mdv_wbck_ready),
        .mdv_wbck_wdat      (mdv_wbck_wdat),
        .longp_wbck_o_valid (longp_wbck_o_valid),
        .longp_wbck_o_ready (longp_wbck_o_ready),
        .longp_wbck_o_wdat  (longp_wbck_o_wdat),
        .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
        .longp_wbck_o_rdfpu (longp_wbck_o_rdfpu),
        .excp_o_valid       (excp_o_valid),
        .excp_o_ready       (excp_o_ready),
        .fifo_empty         (fifo_empty),
        .fifo_cnt           (fifo_cnt)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the DUT disagrees with the model
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check against the model, then advance the model
    task automatic applyStimulus(input stim_t s);
        bit        e_disp_ready, e_lsu_ready, e_mdv_ready, e_longp, e_excp, fire;
        bit [31:0] e_wdat;
        bit [4:0]  e_rdidx;
        bit        e_rdfpu, owner_valid, accept;
        ent_t      h, n;

        @(negedge clk);
        rst                = s.rst;
        disp_valid         = s.disp_valid;
        disp_unit          = s.disp_unit;
        disp_rdwen         = s.disp_rdwen;
        disp_rdidx         = s.disp_rdidx;
        disp_rdfpu         = s.disp_rdfpu;
        flush              = s.flush;
        lsu_wbck_valid     = s.lsu_valid;
        lsu_wbck_wdat      = s.lsu_wdat;
        lsu_wbck_err       = s.lsu_err;
        mdv_wbck_valid     = s.mdv_valid;
        mdv_wbck_wdat      = s.mdv_wdat;
        longp_wbck_o_ready = s.longp_ready;
        excp_o_ready       = s.excp_ready;
        #1;

        e_disp_ready = 0; e_lsu_ready = 0; e_mdv_ready = 0;
        e_longp = 0; e_excp = 0; fire = 0;
        e_wdat = 0; e_rdidx = 0; e_rdfpu = 0;
        if (!s.rst) begin
            e_disp_ready = (model_q.size() < DEPTH) && !s.flush;
            if (model_q.size() > 0 && !s.flush) begin
                h           = model_q[0];
                owner_valid = h.unit ? s.mdv_valid : s.lsu_valid;
                if (!h.unit && s.lsu_err) begin
                    e_excp = owner_valid;
                    accept = s.excp_ready;
                end else if (h.rdwen) begin
                    e_longp = owner_valid;
                    accept  = s.longp_ready;
                    if (owner_valid) begin
                        e_wdat  = h.unit ? s.mdv_wdat : s.lsu_wdat;
                        e_rdidx = h.rdidx;
                        e_rdfpu = h.rdfpu;
                    end
                end else begin
                    accept = 1;
                end
                e_lsu_ready = !h.unit && accept;
                e_mdv_ready = h.unit && accept;
                fire        = owner_valid && accept;
            end
        end

        checkOutput("disp_ready",  32'(disp_ready),         32'(e_disp_ready));
        checkOutput("lsu_ready",   32'(lsu_wbck_ready),     32'(e_lsu_ready));
        checkOutput("mdv_ready",   32'(mdv_wbck_ready),     32'(e_mdv_ready));
        checkOutput("longp_valid", 32'(longp_wbck_o_valid), 32'(e_longp));
        checkOutput("longp_wdat",  longp_wbck_o_wdat,       e_wdat);
        checkOutput("longp_rdidx", 32'(longp_wbck_o_rdidx), 32'(e_rdidx));
        checkOutput("longp_rdfpu", 32'(longp_wbck_o_rdfpu), 32'(e_rdfpu));
        checkOutput("excp_valid",  32'(excp_o_valid),       32'(e_excp));
        checkOutput("fifo_empty",  32'(fifo_empty),         32'(model_q.size() == 0));
        checkOutput("fifo_cnt",    32'(fifo_cnt),           32'(model_q.size()));

        @(posedge clk);
        if (s.rst || s.flush) begin
            model_q.delete();
        end else begin
            if (fire) begin
                void'(model_q.pop_front());
            end
            if (s.disp_valid && e_disp_ready) begin
                n.unit  = s.disp_unit;
                n.rdwen = s.disp_rdwen;
                n.rdidx = s.disp_rdidx;
                n.rdfpu = s.disp_rdfpu;
                model_q.push_back(n);
            end
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t dispStim(input bit unit, input bit rdwen, input bit [4:0] rdidx);
        stim_t s;
        s            = idleStim();
        s.disp_valid = 1;
        s.disp_unit  = unit;
        s.disp_rdwen = rdwen;
        s.disp_rdidx = rdidx;
        return s;
    endfunction

    // Directed scenarios first, then randomized traffic
    initial begin
        stim_t s;
        num_checks      = 0;
        num_miscompares = 0;
        rst = 1; disp_valid = 0; disp_unit = 0; disp_rdwen = 0; disp_rdidx = 0; disp_rdfpu = 0;
        flush = 0; lsu_wbck_valid = 0; lsu_wbck_wdat = 0; lsu_wbck_err = 0;
        mdv_wbck_valid = 0; mdv_wbck_wdat = 0; longp_wbck_o_ready = 0; excp_o_ready = 0;

        s = idleStim(); s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idleStim());

        // LSU write to x5, completed the cycle after dispatch
        applyStimulus(dispStim(0, 1, 5'd5));
        s = idleStim(); s.lsu_valid = 1; s.lsu_wdat = 32'hDEADBEEF; s.longp_ready = 1;
        applyStimulus(s);
        applyStimulus(idleStim());

        // LSU x3 then MULDIV x4; MULDIV answers early and must wait its turn
        applyStimulus(dispStim(0, 1, 5'd3));
        s = dispStim(1, 1, 5'd4); s.mdv_valid = 1; s.mdv_wdat = 32'h44; s.longp_ready = 1;
        applyStimulus(s);
        s = idleStim(); s.mdv_valid = 1; s.mdv_wdat = 32'h44; s.longp_ready = 1;
        applyStimulus(s);
        s.lsu_valid = 1; s.lsu_wdat = 32'h33;
        applyStimulus(s);
        s.lsu_valid = 0;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Fill, then pop with a dispatch pending: the push waits one cycle
        applyStimulus(dispStim(1, 1, 5'd10));
        applyStimulus(dispStim(1, 1, 5'd11));
        s = dispStim(1, 1, 5'd12); s.mdv_valid = 1; s.mdv_wdat = 32'hA; s.longp_ready = 1;
        applyStimulus(s);
        applyStimulus(dispStim(1, 1, 5'd12));
        s = idleStim(); s.mdv_valid = 1; s.mdv_wdat = 32'hB; s.longp_ready = 1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idleStim());

        // Store with no destination is consumed silently
        applyStimulus(dispStim(0, 0, 5'd0));
        s = idleStim(); s.lsu_valid = 1; s.lsu_wdat = 32'h1234;
        applyStimulus(s);
        applyStimulus(idleStim());

        // LSU error held off by the exception port for three cycles
        applyStimulus(dispStim(0, 1, 5'd7));
        s = idleStim(); s.lsu_valid = 1; s.lsu_err = 1; s.longp_ready = 1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(s);
        s.excp_ready = 1;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Flush against dispatch and completion, then reset mid-stream
        applyStimulus(dispStim(1, 1, 5'd1));
        applyStimulus(dispStim(0, 1, 5'd2));
        s = dispStim(1, 1, 5'd3); s.flush = 1; s.mdv_valid = 1; s.longp_ready = 1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(dispStim(1, 1, 5'd8));
        applyStimulus(dispStim(0, 1, 5'd9));
        s = idleStim(); s.rst = 1; s.mdv_valid = 1; s.longp_ready = 1;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Random traffic with rare flush/reset
        for (int i = 0; i < 3000; i++) begin
            s             = idleStim();
            s.rst         = ($urandom_range(0, 99) == 0);
            s.flush       = ($urandom_range(0, 29) == 0);
            s.disp_valid  = ($urandom_range(0, 1) == 1);
            s.disp_unit   = 1'($urandom);
            s.disp_rdwen  = ($urandom_range(0, 3) != 0);
            s.disp_rdidx  = 5'($urandom);
            s.disp_rdfpu  = 1'($urandom);
            s.lsu_valid   = ($urandom_range(0, 2) != 0);
            s.lsu_wdat    = $urandom;
            s.lsu_err     = ($urandom_range(0, 5) == 0);
            s.mdv_valid   = ($urandom_range(0, 2) != 0);
            s.mdv_wdat    = $urandom;
            s.longp_ready = ($urandom_range(0, 3) != 0);
            s.excp_ready  = 1'($urandom);
            applyStimulus(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_miscompares);
        $finish;
    end

endmodule

// File: doc/e203_exu_longp_wbck_sched.md
Name: e203_exu_longp_wbck_sched

Overview:
In-order scheduler for long-pipeline write-back. It records each dispatched long-pipe instruction (LSU or MULDIV) in a small tag FIFO. It accepts completion responses only from the unit that owns the FIFO head, and presents that response on the longp write-back interface feeding the regfile write-back arbiter. Completions with errors are diverted to an exception port instead of the regfile.

Parameters:
DEPTH, 2, tag FIFO entries; power of 2, at least 2
PTR_W, 1, log2(DEPTH)
XLEN, 32, data width
RFIDX_W, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
disp_valid  in  1  long-pipe instruction dispatch
disp_ready  out  1  FIFO can accept
disp_unit  in  1  0=LSU, 1=MULDIV
disp_rdwen  in  1  instruction writes rd
disp_rdidx  in  RFIDX_W  destination index
disp_rdfpu  in  1  destination is FPU regfile
flush  in  1  pipeline flush; discard all entries
lsu_wbck_valid  in  1  LSU completion
lsu_wbck_ready  out  1
lsu_wbck_wdat  in  XLEN
lsu_wbck_err  in  1  LSU bus/access error
mdv_wbck_valid  in  1  MULDIV completion
mdv_wbck_ready  out  1
mdv_wbck_wdat  in  XLEN
longp_wbck_o_valid  out  1  to write-back arbiter
longp_wbck_o_ready  in  1
longp_wbck_o_wdat  out  XLEN
longp_wbck_o_rdidx  out  RFIDX_W
longp_wbck_o_rdfpu  out  1
excp_o_valid  out  1  errored completion
excp_o_ready  in  1
fifo_empty  out  1  no outstanding long-pipe instruction
fifo_cnt  out  PTR_W+1  occupancy

Behaviour:
- State: DEPTH entries of {unit, rdwen, rdidx, rdfpu}; wr_ptr and rd_ptr, each PTR_W+1 bits with a wrap bit.
- empty = (wr_ptr == rd_ptr); full = MSBs differ and LSBs are equal.
- Reset (rst high at a clock edge): pointers = 0, entries = 0. While rst is high, disp_ready = 0 and all *_ready/*_valid outputs = 0. After reset: fifo_empty = 1, fifo_cnt = 0, disp_ready = 1.
- Push: disp_valid & disp_ready. disp_ready = ~full & ~flush. There is no bypass: an entry becomes visible as head one cycle after the push, so minimum dispatch-to-write-back is 1 cycle.
- Head select: hd_lsu = ~empty & head.unit==0; hd_mdv = ~empty & head.unit==1. A unit's response is ignored (ready = 0) unless that unit owns the head.
- Head response classes, where v = valid of the owning unit:
  - Normal write (rdwen=1, err=0): longp_wbck_o_valid = v; unit ready = longp_wbck_o_ready.
  - No-rd completion (rdwen=0, err=0), e.g. a store: longp_wbck_o_valid = 0; unit ready = 1; the completion is consumed silently.
  - LSU error (err=1): excp_o_valid = v; longp_wbck_o_valid = 0; lsu ready = excp_o_ready.
  - lsu_wbck_err is ignored for MULDIV heads.
- longp_wbck_o_wdat/rdidx/rdfpu come from the head unit data and head entry fields. They are combinational and valid only when longp_wbck_o_valid = 1; otherwise they are 0.
- Pop: handshake of the head unit (valid & ready). rd_ptr increments modulo 2*DEPTH.
- Push and pop in the same cycle: both pointers advance and fifo_cnt is unchanged. Full plus pop in the same cycle does not allow a push that cycle.
- flush: synchronously sets rd_ptr = wr_ptr. It has priority over push and pop in the same cycle. While flush = 1, all unit readies = 0 and longp_wbck_o_valid = excp_o_valid = 0. Units must drop in-flight responses on the same flush.
- Error responses still pop the entry. Exception routing beyond excp_o is the commit logic's job.
- fifo_cnt = wr_ptr - rd_ptr (modular).
- At most one of longp_wbck_o_valid and excp_o_valid is high in any cycle.

Decomposition:
- Package e203_wbck_pkg holds:
  - unit encodings: UNIT_LSU = 1'b0, UNIT_MDV = 1'b1
  - entry typedef wbck_tag_t {unit, rdwen, rdidx, rdfpu}
  - default DEPTH
- One sub-module, e203_exu_wbck_tagfifo: parameterised sync FIFO with flush, full/empty and count outputs, exposing the head entry.
- Head decode and response muxing stay in the top module.

Test Plan:
- Reset then dispatch LSU rd=x5. Next cycle lsu_wbck_valid with wdat=0xDEADBEEF, longp_ready=1 -> longp_wbck_o_valid=1, rdidx=5, wdat=0xDEADBEEF; fifo_cnt goes 1->0.
- Dispatch LSU x3, then MULDIV x4. mdv_valid is asserted first -> mdv_ready=0 until the LSU completes. Write-backs appear in order x3 then x4.
- Fill to DEPTH=2 -> disp_ready=0. Pop one and present disp_valid in the same cycle -> no push that cycle; push next cycle; fifo_cnt stays 2.
- Dispatch LSU store rdwen=0; lsu_valid -> lsu_ready=1, longp_wbck_o_valid=0, entry popped, fifo_empty=1.
- LSU err=1 with excp_o_ready=0 for 3 cycles -> excp_o_valid held, lsu_ready=0, no regfile write. Pops when ready=1.
- Two entries outstanding, assert flush concurrent with disp_valid and mdv_valid -> no push, no pop; next cycle fifo_empty=1, cnt=0. Assert rst mid-operation -> same empty state.
